torreta_uc: RTL and testbench

Control unit for the turret datapath (`torreta_fd`). It sequences each scan step: measure, transmit, decide, and, when a threat is confirmed, fire, optionally reload, and rotate. It owns the HC-SR04 measurement watchdog. It sits beside `torreta_fd` in the top level, driving the datapath's command inputs from the datapath's status outputs.

---
 rtl/torreta_pkg.sv | 25 ++
 rtl/torreta_uc_contador_timeout.sv | 30 +++
 rtl/torreta_uc.sv | 127 ++++++++++++
 tb/tb_torreta_uc.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/torreta_pkg.sv
// Shared definitions for the turret control unit: state codes, debug width and
// the default magazine capacity.
package torreta_pkg;

    localparam int DB_ESTADO_W        = 4;
    localparam int MUNICAO_MAX_PADRAO = 4;

    typedef enum logic [DB_ESTADO_W-1:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TIMEOUT        = 4'd4,
        TRANSMITE      = 4'd5,
        AGUARDA_ENVIO  = 4'd6,
        DECIDE         = 4'd7,
        DISPARA        = 4'd8,
        RECARGA        = 4'd9,
        SOMA           = 4'd10,
        SEM_MUNICAO    = 4'd11,
        ESPERA         = 4'd12,
        GIRA           = 4'd13
    } estado_t;

endpackage

// File: rtl/torreta_uc_contador_timeout.sv
// Measurement watchdog: counts while enabled, saturates at CICLOS-1 and
// raises fim there; limpa forces it back to zero.
module contador_timeout #(
    parameter int CICLOS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic habilita,
    output logic fim
);

    localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;
    localparam logic [W-1:0] TERMINAL = W'(CICLOS - 1);

    logic [W-1:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (limpa) begin
            valor <= '0;
        end else if (habilita && !fim) begin
            valor <= valor + 1'b1;
        end
    end

    assign fim = (valor == TERMINAL);

endmodule

// File: rtl/torreta_uc.sv
// Turret scan-step sequencer (Moore FSM) with the HC-SR04 measurement watchdog.
// Define TORRETA_RECARGA_AUTO_EN to refill an empty magazine instead of flagging sem_municao.
module torreta_uc
    import torreta_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 2_500_000,
    parameter int MUNICAO_MAX    = MUNICAO_MAX_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ligar,
    input  logic                   medida_pronto,
    input  logic                   envio_pronto,
    input  logic                   fim_tempo,
    input  logic                   ameaca_detectada,
    input  logic                   fim_disparo,
    input  logic                   fim_recarga,
    input  logic [3:0]             contagem_municao,
    output logic                   zera,
    output logic                   medir,
    output logic                   transmitir,
    output logic                   girar,
    output logic                   soma_municao,
    output logic                   timeout_medicao,
    output logic                   conta,
    output logic                   dispara,
    output logic                   recarrega,
    output logic                   sem_municao,
    output logic [DB_ESTADO_W-1:0] db_estado
);

    estado_t estado;
    estado_t proximo;
    logic    fim_watchdog;
    logic    aguardando;
    logic    municao_cheia;

    assign aguardando = (estado == AGUARDA_MEDIDA);

    contador_timeout #(
        .CICLOS(TIMEOUT_CICLOS)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .limpa    (!aguardando),
        .habilita (aguardando),
        .fim      (fim_watchdog)
    );

    // Compared against the count before this SOMA's increment lands.
    assign municao_cheia = (int'(contagem_municao) >= MUNICAO_MAX - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:        if (ligar) proximo = PREPARA;
            PREPARA:        proximo = MEDE;
            MEDE:           proximo = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                if (medida_pronto)     proximo = TRANSMITE;
                else if (fim_watchdog) proximo = TIMEOUT;
            end
            TIMEOUT:        proximo = GIRA;
            TRANSMITE:      proximo = AGUARDA_ENVIO;
            AGUARDA_ENVIO:  if (envio_pronto) proximo = DECIDE;
            DECIDE: begin
                if (ameaca_detectada && contagem_municao != 4'd0) begin
                    proximo = DISPARA;
                end else if (ameaca_detectada) begin
`ifdef TORRETA_RECARGA_AUTO_EN
                    proximo = RECARGA;
`else
                    proximo = SEM_MUNICAO;
`endif
                end else begin
                    proximo = ESPERA;
                end
            end
            DISPARA:        if (fim_disparo) proximo = ESPERA;
            RECARGA:        if (fim_recarga) proximo = SOMA;
            SOMA:           proximo = municao_cheia ? ESPERA : RECARGA;
            SEM_MUNICAO:    proximo = ESPERA;
            ESPERA:         if (fim_tempo) proximo = ligar ? GIRA : INICIAL;
            GIRA:           proximo = MEDE;
            default:        proximo = INICIAL;
        endcase
    end

    always_comb begin
        zera            = 1'b0;
        medir           = 1'b0;
        transmitir      = 1'b0;
        girar           = 1'b0;
        soma_municao    = 1'b0;
        timeout_medicao = 1'b0;
        conta           = 1'b0;
        dispara         = 1'b0;
        recarrega       = 1'b0;
        sem_municao     = 1'b0;
        case (estado)
            PREPARA:     zera            = 1'b1;
            MEDE:        medir           = 1'b1;
            TIMEOUT:     timeout_medicao = 1'b1;
            TRANSMITE:   transmitir      = 1'b1;
            DISPARA:     dispara         = 1'b1;
`ifdef TORRETA_RECARGA_AUTO_EN
            RECARGA:     recarrega       = 1'b1;
            SOMA:        soma_municao    = 1'b1;
`endif
            SEM_MUNICAO: sem_municao     = 1'b1;
            ESPERA:      conta           = 1'b1;
            GIRA:        girar           = 1'b1;
            default:     ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_torreta_uc.sv
// Bench for torreta_uc: a procedural scan-step model predicts state code and
// outputs every cycle; directed steps pin latencies and boundary cases with literals.
module tb_torreta_uc;

    localparam int TMO = 16;
    localparam int MUN = 4;

    localparam logic [9:0] O_ZERA  = 10'b0000000001;
    localparam logic [9:0] O_MEDIR = 10'b0000000010;
    localparam logic [9:0] O_TX    = 10'b0000000100;
    localparam logic [9:0] O_GIRA  = 10'b0000001000;
    localparam logic [9:0] O_SOMA  = 10'b0000010000;
    localparam logic [9:0] O_TMO   = 10'b0000100000;
    localparam logic [9:0] O_CONTA = 10'b0001000000;
    localparam logic [9:0] O_DISP  = 10'b0010000000;
    localparam logic [9:0] O_REC   = 10'b0100000000;
    localparam logic [9:0] O_SEM   = 10'b1000000000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       medida_pronto = 1'b0;
    logic       envio_pronto = 1'b0;
    logic       fim_tempo = 1'b0;
    logic       ameaca_detectada = 1'b0;
    logic       fim_disparo = 1'b0;
    logic       fim_recarga = 1'b0;
    logic [3:0] contagem_municao = 4'd0;
    logic       zera, medir, transmitir, girar, soma_municao, timeout_medicao;
    logic       conta, dispara, recarrega, sem_municao;
    logic [3:0] db_estado;
    logic [9:0] act_o;

    int n_checks = 0;
    int n_pass = 0;

    logic [3:0] exp_code = 4'd0;
    logic [9:0] exp_o = '0;
    bit         aborted = 1'b0;

    bit soma_seen = 1'b0;
    int cnt_tx = 0, cnt_girar = 0, cnt_tmo = 0, cnt_soma = 0;
    int cnt_rec = 0, cnt_sem = 0, cnt_disp = 0;

    torreta_uc #(
        .TIMEOUT_CICLOS(TMO),
        .MUNICAO_MAX(MUN)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ligar            (ligar),
        .medida_pronto    (medida_pronto),
        .envio_pronto     (envio_pronto),
        .fim_tempo        (fim_tempo),
        .ameaca_detectada (ameaca_detectada),
        .fim_disparo      (fim_disparo),
        .fim_recarga      (fim_recarga),
        .contagem_municao (contagem_municao),
        .zera             (zera),
        .medir            (medir),
        .transmitir       (transmitir),
        .girar            (girar),
        .soma_municao     (soma_municao),
        .timeout_medicao  (timeout_medicao),
        .conta            (conta),
        .dispara          (dispara),
        .recarrega        (recarrega),
        .sem_municao      (sem_municao),
        .db_estado        (db_estado)
    );

    assign act_o = {sem_municao, recarrega, dispara, conta, timeout_medicao,
                    soma_municao, girar, transmitir, medir, zera};

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // One call = one cycle showing (code, outputs); returns after the edge that ends it,
    // when the inputs seen by that edge are still on the bench wires.
    task automatic cyc(input int code, input logic [9:0] o);
        exp_code = 4'(code);
        exp_o    = o;
        @(posedge clock or negedge reset);
        if (!reset) aborted = 1'b1;
    endtask

    task automatic run_session();
        bit got;
        do begin
            cyc(0, '0); if (aborted) return;
        end while (!ligar);
        cyc(1, O_ZERA); if (aborted) return;
        forever begin
            cyc(2, O_MEDIR); if (aborted) return;
            got = 1'b0;
            for (int k = 0; k < TMO; k++) begin
                cyc(3, '0); if (aborted) return;
                if (medida_pronto) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                cyc(4, O_TMO); if (aborted) return;
            end else begin
                cyc(5, O_TX); if (aborted) return;
                do begin
                    cyc(6, '0); if (aborted) return;
                end while (!envio_pronto);
                cyc(7, '0); if (aborted) return;
                if (ameaca_detectada && contagem_municao != 4'd0) begin
                    do begin
                        cyc(8, O_DISP); if (aborted) return;
                    end while (!fim_disparo);
                end else if (ameaca_detectada) begin
`ifdef TORRETA_RECARGA_AUTO_EN
                    forever begin
                        do begin
                            cyc(9, O_REC); if (aborted) return;
                        end while (!fim_recarga);
                        cyc(10, O_SOMA); if (aborted) return;
                        if (int'(contagem_municao) >= MUN - 1) break;
                    end
`else
                    cyc(11, O_SEM); if (aborted) return;
`endif
                end
                do begin
                    cyc(12, O_CONTA); if (aborted) return;
                end while (!fim_tempo);
                if (!ligar) return;
            end
            cyc(13, O_GIRA); if (aborted) return;
        end
    endtask

    initial begin
        forever begin
            wait (reset === 1'b1);
            aborted = 1'b0;
            run_session();
        end
    end

    // ---------------- per-cycle compare + event counters ----------------
    initial begin
        logic [13:0] want;
        forever begin
            @(negedge clock);
            soma_seen = soma_municao;
            cnt_tx    += int'(transmitir);
            cnt_girar += int'(girar);
            cnt_tmo   += int'(timeout_medicao);
            cnt_soma  += int'(soma_municao);
            cnt_rec   += int'(recarrega);
            cnt_sem   += int'(sem_municao);
            cnt_disp  += int'(dispara);
            want = reset ? {exp_code, exp_o} : 14'd0;
            n_checks++;
            if ({db_estado, act_o} === want) n_pass++;
            else $display("FAIL model_cycle t=%0t: db_estado=%0d outs=%b, model wants db_estado=%0d outs=%b",
                          $time, db_estado, act_o, want[13:10], want[9:0]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
        if (soma_seen && contagem_municao != 4'hf) contagem_municao = contagem_municao + 4'd1;
    endtask

    task automatic wait_code(input int code, input string name);
        for (int i = 0; i < 64 && int'(db_estado) != code; i++) tick();
        check(name, int'(db_estado), code);
    endtask

    initial begin
        int n, g0, t0, tm0, d0, s0, r0, sm0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // 1: reset in the middle of DISPARA
        ligar = 1'b1; ameaca_detectada = 1'b1; contagem_municao = 4'd3;
        medida_pronto = 1'b1; envio_pronto = 1'b1;
        wait_code(8, "reach_dispara");
        reset = 1'b0;
        #1;
        check("rst_dispara", int'(dispara), 0);
        check("rst_db_estado", int'(db_estado), 0);
        check("rst_outputs", int'(act_o), 0);
        medida_pronto = 1'b0; envio_pronto = 1'b0; ameaca_detectada = 1'b0; ligar = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        ligar = 1'b1;
        tick();
        check("zera_after_ligar", int'(zera), 1);
        check("prepara_code", int'(db_estado), 1);
        tick();
        check("medir_2clk_after_ligar", int'(medir), 1);

        // 2: no threat, medida_pronto in the 5th waiting cycle
        tick();
        check("aguarda_entry", int'(db_estado), 3);
        repeat (4) tick();
        medida_pronto = 1'b1;
        tick();
        check("transmitir_after_medida", int'(transmitir), 1);
        medida_pronto = 1'b0;
        tick();
        envio_pronto = 1'b1;
        tick();
        check("decide_code", int'(db_estado), 7);
        envio_pronto = 1'b0;
        tick();
        check("espera_conta", int'(conta), 1);
        g0 = cnt_girar;
        fim_tempo = 1'b1;
        tick();
        check("girar_after_fim_tempo", int'(girar), 1);
        fim_tempo = 1'b0;
        tick();
        check("medir_after_girar", int'(medir), 1);
        tick();
        check("single_girar", cnt_girar - g0, 1);

        // 3: watchdog expiry, then medida_pronto on the terminal cycle
        t0 = cnt_tx;
        n = 0;
        while (!timeout_medicao && n < 40) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 16);
        tick();
        check("girar_after_timeout", int'(girar), 1);
        check("no_tx_on_timeout", cnt_tx - t0, 0);
        tick(); tick();
        check("aguarda_again", int'(db_estado), 3);
        repeat (15) tick();
        medida_pronto = 1'b1;
        tm0 = cnt_tmo;
        tick();
        check("medida_wins_terminal", int'(transmitir), 1);
        medida_pronto = 1'b0;
        tick();
        ameaca_detectada = 1'b1; contagem_municao = 4'd3; envio_pronto = 1'b1;
        tick();
        envio_pronto = 1'b0;
        d0 = cnt_disp;
        tick();

        // 4: threat with ammo, fim_disparo after 10 held cycles
        check("dispara_rise", int'(dispara), 1);
        repeat (10) tick();
        fim_disparo = 1'b1;
        tick();
        fim_disparo = 1'b0;
        check("espera_after_disparo", int'(db_estado), 12);
        check("dispara_cycles", cnt_disp - d0, 11);
        check("no_timeout_terminal", cnt_tmo - tm0, 0);

        // 5: threat with an empty magazine
        fim_tempo = 1'b1;
        tick();
        fim_tempo = 1'b0;
        tick();
        medida_pronto = 1'b1;
        tick(); tick();
        medida_pronto = 1'b0;
        envio_pronto = 1'b1; contagem_municao = 4'd0; fim_recarga = 1'b1;
        s0 = cnt_soma; r0 = cnt_rec; sm0 = cnt_sem; d0 = cnt_disp;
        tick(); tick();
        envio_pronto = 1'b0;
        wait_code(12, "espera_after_empty");
`ifdef TORRETA_RECARGA_AUTO_EN
        check("soma_pulses", cnt_soma - s0, 4);
        check("recarga_cycles", cnt_rec - r0, 4);
        check("count_refilled", int'(contagem_municao), 4);
        check("no_sem_municao", cnt_sem - sm0, 0);
`else
        check("sem_municao_pulses", cnt_sem - sm0, 1);
        check("no_recarga", cnt_rec - r0, 0);
        check("no_soma", cnt_soma - s0, 0);
`endif
        check("no_fire_empty", cnt_disp - d0, 0);

        // 6: ligar dropped while waiting for the transmission
        fim_recarga = 1'b0; ameaca_detectada = 1'b0;
        fim_tempo = 1'b1;
        tick();
        fim_tempo = 1'b0;
        tick();
        medida_pronto = 1'b1;
        tick(); tick();
        medida_pronto = 1'b0;
        tick();
        check("aguarda_envio_code", int'(db_estado), 6);
        ligar = 1'b0;
        repeat (3) tick();
        envio_pronto = 1'b1;
        tick();
        envio_pronto = 1'b0;
        tick();
        check("espera_without_ligar", int'(db_estado), 12);
        g0 = cnt_girar;
        fim_tempo = 1'b1;
        tick();
        fim_tempo = 1'b0;
        check("inicial_after_stop", int'(db_estado), 0);
        tick(); tick();
        check("no_girar_after_stop", cnt_girar - g0, 0);
        check("stays_inicial", int'(db_estado), 0);

        // randomized traffic, occasional resets
        repeat (4000) begin
            tick();
            ligar            = ($urandom_range(0, 15) != 0);
            medida_pronto    = ($urandom_range(0, 9) == 0);
            envio_pronto     = ($urandom_range(0, 3) == 0);
            fim_tempo        = ($urandom_range(0, 5) == 0);
            ameaca_detectada = 1'($urandom_range(0, 1));
            fim_disparo      = ($urandom_range(0, 4) == 0);
            fim_recarga      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) contagem_municao = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                tick(); tick();
                reset = 1'b1;
            end
        end

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
